single_inv_checker: RTL and testbench
=====================================

Name: single_inv_checker

Overview:
- Self-checking response monitor sitting directly downstream of the single_inv DUT in board-level and simulation harnesses.
- Samples the stimulus driven into the DUT (d_in) and the DUT's response (d_out).
- Compares each response against the inverted stimulus after a fixed pipeline latency.
- Reports pass/fail, error count and first-failure index for a run of N vectors.

Parameters:
LATENCY, 1, DUT clock cycles from d_in sample to matching d_out sample; 0..15 legal, 0 = combinational DUT
CNT_W, 16, width of vector/error counters and num_vectors

Ports:
clock  input  1  single clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a run (honoured only in IDLE or DONE)
num_vectors  input  CNT_W  number of vectors in run, sampled on start edge
d_in  input  1  stimulus value presented to DUT
d_out  input  1  DUT response
busy  output  1  high in ISSUE or DRAIN
done  output  1  high in DONE
pass  output  1  valid when done; 1 iff err_count == 0
err_count  output  CNT_W  mismatches this run, saturating at all-ones
vec_count  output  CNT_W  vectors compared this run
first_err_idx  output  CNT_W  index of first mismatching vector; meaningful only when err_count != 0

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; busy=0, done=0, pass=0, err_count=0, vec_count=0, first_err_idx=0.
  - Delay line and valid pipe are cleared.
  - rst overrides start and aborts any run in progress; no partial result is kept.
- Timing:
  - Start edge = t0. Vector i is the d_in value sampled at edge t0+i, for i = 0..N-1.
  - Its response is d_out sampled at edge t0+i+LATENCY.
  - Expected response = ~d_in(vector i).
- Implementation:
  - LATENCY-deep shift register of d_in plus a parallel valid shift register.
  - A compare occurs at an edge where the delayed valid bit is 1. For LATENCY=0, the compare uses the current d_in and valid directly.
- FSM:
  - IDLE: start=1 → latch N=num_vectors, clear counters/first_err_idx. N=0 goes to DONE; otherwise push vector 0 (valid=1) and go to ISSUE.
  - ISSUE: push valid=1 each edge. After N vectors have been pushed, go to DRAIN, or to DONE directly when LATENCY=0.
  - DRAIN: push valid=0. When the last valid compare has occurred, go to DONE.
  - DONE: holds results. start=1 behaves as in IDLE: clear counters and begin a new run. Results from the previous run stay visible until that edge.
- Result timing: done rises at edge t0+N+LATENCY, i.e. the edge after the last compare. For N=0, done rises at t0+1.
- Compare edge:
  - vec_count += 1.
  - On mismatch: err_count += 1, saturating at 2^CNT_W-1.
  - If err_count was 0 before the increment, first_err_idx = index of that vector (= vec_count before increment).
- pass: registered; updated as (err_count==0) on the DONE-entry edge; cleared to 0 when a new run starts.
- start while busy: ignored, with no effect on counters.
- Outputs are registered only; no combinational path from inputs to outputs.
- X/Z on d_out is not specially handled; it is treated per RTL comparison semantics.

Optional Feature:
- Macro: SINGLE_INV_CHECKER_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch forces a transition to DONE on the edge after that compare.
  - vec_count includes the failing vector; remaining vectors and the pipeline are discarded.
  - pass=0.
  - err_count = 1 unless multiple compares land on the same edge (impossible: one compare per edge), so err_count is exactly 1.
- Not defined: the run always completes all N vectors and counts all mismatches.

Test Plan:
- LATENCY=1, start with N=8, d_in pattern 0,1,1,0,1,0,0,1, d_out = registered ~d_in → done at t0+9, pass=1, err_count=0, vec_count=8.
- LATENCY=1, N=8, d_out stuck at 0 → err_count=4 (vectors 0,3,5,6 mismatch), first_err_idx=0, pass=0, vec_count=8.
- LATENCY=0, N=4, d_out=~d_in except vector 2 corrupted → done at t0+4, err_count=1, first_err_idx=2, pass=0.
- N=0 start → done=1 at t0+1, pass=1, vec_count=0. Start pulsed again while busy in a 16-vector run → ignored, vec_count ends at 16.
- Assert rst mid-run at vector 3 of 8 → next cycle state IDLE, all outputs 0. New start with N=2 and correct DUT → pass=1, vec_count=2.
- STOP_ON_ERR_EN defined, N=8, mismatch at vector 2 → done at the edge after vector 2's compare, vec_count=3, err_count=1, first_err_idx=2, pass=0.

Source files
------------

// File: rtl/single_inv_checker.sv
// single_inv_checker
//   Response monitor for the single_inv DUT. For a run of N vectors it compares
//   each DUT response against the inverted stimulus LATENCY clocks later. It
//   reports pass/fail, the mismatch count and the index of the first mismatch.
//
// Parameters
//   LATENCY  DUT latency in clocks (0..15, 0 = combinational DUT)
//   CNT_W    width of num_vectors and of the result counters
//
// Ports
//   clock          rising-edge clock
//   rst            synchronous, active-high reset
//   start          one-cycle pulse; honoured only when idle or done
//   num_vectors    run length, sampled with start
//   d_in           stimulus presented to the DUT
//   d_out          DUT response
//   busy           run in progress (issuing or draining)
//   done           run finished, results valid
//   pass           1 iff the finished run saw no mismatches
//   err_count      mismatches this run, saturating
//   vec_count      vectors compared this run
//   first_err_idx  index of first mismatching vector (valid when err_count != 0)
//
// Build option
//   SINGLE_INV_CHECKER_STOP_ON_ERR_EN: end the run at the first mismatch and
//   discard the rest of the pipeline.

module single_inv_checker #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             d_in,
  input  logic             d_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] w_issued_nxt;
  logic [CNT_W-1:0] w_n_eff;
  logic [CNT_W-1:0] w_vec_base;
  logic [CNT_W-1:0] w_err_base;
  logic [CNT_W-1:0] w_vec_nxt;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_first_nxt;
  logic             w_pass_nxt;
  logic             w_start;
  logic             w_push_vld;
  logic             w_cmp_vld;
  logic             w_cmp_d;
  logic             w_mis;
  logic             w_last;
  logic             w_stop;

  // Start acceptance and the valid bit pushed into the delay line this edge.
  always_comb begin
    w_start    = start && (r_state == S_IDLE || r_state == S_DONE);
    w_push_vld = 1'b0;
    if (w_start) begin
      w_push_vld = (num_vectors != '0);
    end else if (r_state == S_ISSUE) begin
      w_push_vld = (r_issued != r_n);
    end
  end

  // Stimulus delay line; the tail stage lines up with the DUT response.
  generate
    if (LATENCY == 0) begin : g_comb
      assign w_cmp_vld = w_push_vld;
      assign w_cmp_d   = d_in;
    end else begin : g_pipe
      logic [LATENCY-1:0] r_dly;
      logic [LATENCY-1:0] r_vld;

      always_ff @(posedge clock) begin
        if (rst) begin
          r_dly <= '0;
          r_vld <= '0;
        end else begin
          r_dly[0] <= d_in;
          r_vld[0] <= w_push_vld && !w_stop;
          for (int unsigned k = 1; k < LATENCY; k++) begin
            r_dly[k] <= r_dly[k-1];
            r_vld[k] <= r_vld[k-1] && !w_stop;
          end
        end
      end

      assign w_cmp_vld = r_vld[LATENCY-1];
      assign w_cmp_d   = r_dly[LATENCY-1];
    end
  endgenerate

  // Counter update. A start edge restarts from zero, and with LATENCY=0 the
  // first compare of the new run lands on that same edge, so the compare is
  // applied on top of the cleared base values.
  always_comb begin
    w_n_eff     = w_start ? num_vectors : r_n;
    w_vec_base  = w_start ? '0 : vec_count;
    w_err_base  = w_start ? '0 : err_count;
    w_vec_nxt   = w_vec_base;
    w_err_nxt   = w_err_base;
    w_first_nxt = w_start ? '0 : first_err_idx;
    w_mis       = w_cmp_vld && (d_out != ~w_cmp_d);
    if (w_cmp_vld) begin
      w_vec_nxt = w_vec_base + CNT_W'(1);
      if (w_mis) begin
        if (w_err_base != '1) begin
          w_err_nxt = w_err_base + CNT_W'(1);
        end
        if (w_err_base == '0) begin
          w_first_nxt = w_vec_base;
        end
      end
    end
    w_last = w_cmp_vld && (w_vec_nxt == w_n_eff);
`ifdef SINGLE_INV_CHECKER_STOP_ON_ERR_EN
    w_stop = w_mis;
`else
    w_stop = 1'b0;
`endif
  end

  // State transitions. DONE is entered on the edge of the final compare so
  // that done is seen on the following edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_issued_nxt = r_issued;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_issued_nxt = w_push_vld ? CNT_W'(1) : '0;
          if (num_vectors == '0 || w_last || w_stop) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_push_vld) begin
          w_issued_nxt = r_issued + CNT_W'(1);
        end
        if (w_last || w_stop) begin
          w_state_nxt = S_DONE;
        end else if (w_issued_nxt == r_n) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last || w_stop) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_pass_nxt = pass;
    if (w_start) begin
      w_pass_nxt = 1'b0;
    end
    if (w_state_nxt == S_DONE && (r_state != S_DONE || w_start)) begin
      w_pass_nxt = (w_err_nxt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_n           <= '0;
      r_issued      <= '0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      pass          <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_issued      <= w_issued_nxt;
      vec_count     <= w_vec_nxt;
      err_count     <= w_err_nxt;
      first_err_idx <= w_first_nxt;
      pass          <= w_pass_nxt;
      if (w_start) begin
        r_n <= num_vectors;
      end
    end
  end

  always_comb begin
    busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_single_inv_checker.sv
// tb_single_inv_checker
//   Drives three checker instances (LATENCY 0, 1 and 3) with shared stimulus
//   and per-instance DUT responses, records their outputs every cycle and
//   compares them with results computed from the recorded stimulus/response
//   history.

module tb_single_inv_checker;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vectors;
  logic        d_in;
  logic [2:0]  dout_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  pass_v;
  logic [15:0] err_v [3];
  logic [15:0] vec_v [3];
  logic [15:0] fe_v  [3];

  int lat [3] = '{0, 1, 3};

  int n_total = 0;
  int n_bad   = 0;

  bit          obs_done [3][64];
  bit          obs_busy [3][64];
  bit          obs_pass [3][64];
  logic        din_h [64];
  logic        dout_h [3][64];

  always #5 clock = ~clock;

  single_inv_checker #(.LATENCY(0), .CNT_W(16)) u_dut0 (
    .clock(clock), .rst(rst), .start(start), .num_vectors(num_vectors),
    .d_in(d_in), .d_out(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .vec_count(vec_v[0]),
    .first_err_idx(fe_v[0]));

  single_inv_checker #(.LATENCY(1), .CNT_W(16)) u_dut1 (
    .clock(clock), .rst(rst), .start(start), .num_vectors(num_vectors),
    .d_in(d_in), .d_out(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .vec_count(vec_v[1]),
    .first_err_idx(fe_v[1]));

  single_inv_checker #(.LATENCY(3), .CNT_W(16)) u_dut2 (
    .clock(clock), .rst(rst), .start(start), .num_vectors(num_vectors),
    .d_in(d_in), .d_out(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_v[2]), .vec_count(vec_v[2]),
    .first_err_idx(fe_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("%s.busy[%0d]", tag, j), {31'd0, busy_v[j]}, 0);
      check($sformatf("%s.done[%0d]", tag, j), {31'd0, done_v[j]}, 0);
      check($sformatf("%s.pass[%0d]", tag, j), {31'd0, pass_v[j]}, 0);
      check($sformatf("%s.err[%0d]", tag, j), {16'd0, err_v[j]}, 0);
      check($sformatf("%s.vec[%0d]", tag, j), {16'd0, vec_v[j]}, 0);
      check($sformatf("%s.first[%0d]", tag, j), {16'd0, fe_v[j]}, 0);
    end
  endtask

  // mode: 0 correct DUT, 1 stuck at 0, 2 sparse random flips,
  //       3 fully random response, 4 correct except vector 2 inverted.
  // poke: cycle at which an extra start pulse is issued mid-run (-1 = none).
  task automatic run_vec(input int n, input int mode, input bit use_pat,
                         input logic [31:0] pat, input int poke);
    int   maxc;
    int   idx;
    logic good;
    logic val;
    int   cnt, errs, first, dc;
    bit   mm;
    maxc = n + 5;
    num_vectors = 16'(n);
    for (int c = 0; c < maxc; c++) begin
      start = (c == 0) || (c == poke);
      d_in  = (use_pat && c < n) ? pat[c] : 1'($urandom_range(0, 1));
      din_h[c] = d_in;
      for (int j = 0; j < 3; j++) begin
        idx = c - lat[j];
        val = 1'($urandom_range(0, 1));
        if (idx >= 0 && idx < n) begin
          good = ~din_h[idx];
          case (mode)
            0: val = good;
            1: val = 1'b0;
            2: val = ($urandom_range(0, 3) == 0) ? ~good : good;
            4: val = (idx == 2) ? ~good : good;
            default: ;
          endcase
        end
        dout_v[j]    = val;
        dout_h[j][c] = val;
      end
      tick();
      for (int j = 0; j < 3; j++) begin
        obs_done[j][c] = done_v[j];
        obs_busy[j][c] = busy_v[j];
        obs_pass[j][c] = pass_v[j];
      end
    end
    start = 1'b0;

    for (int j = 0; j < 3; j++) begin
      cnt = 0; errs = 0; first = 0;
      for (int i = 0; i < n; i++) begin
        mm = (dout_h[j][i + lat[j]] !== ~din_h[i]);
        cnt++;
        if (mm) begin
          if (errs == 0) first = i;
          errs++;
`ifdef SINGLE_INV_CHECKER_STOP_ON_ERR_EN
          break;
`endif
        end
      end
      dc = (cnt == 0) ? 0 : cnt - 1 + lat[j];
      for (int c = 0; c < maxc; c++) begin
        check($sformatf("n%0d.m%0d.L%0d.done@%0d", n, mode, lat[j], c),
              {31'd0, obs_done[j][c]}, (c >= dc) ? 1 : 0);
        check($sformatf("n%0d.m%0d.L%0d.busy@%0d", n, mode, lat[j], c),
              {31'd0, obs_busy[j][c]}, (c < dc) ? 1 : 0);
        check($sformatf("n%0d.m%0d.L%0d.pass@%0d", n, mode, lat[j], c),
              {31'd0, obs_pass[j][c]}, (c >= dc && errs == 0) ? 1 : 0);
      end
      check($sformatf("n%0d.m%0d.L%0d.vec", n, mode, lat[j]), {16'd0, vec_v[j]}, cnt);
      check($sformatf("n%0d.m%0d.L%0d.err", n, mode, lat[j]), {16'd0, err_v[j]}, errs);
      if (errs != 0)
        check($sformatf("n%0d.m%0d.L%0d.first", n, mode, lat[j]), {16'd0, fe_v[j]}, first);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_vectors = '0;
    d_in = 1'b0;
    dout_v = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // pattern 0,1,1,0,1,0,0,1 with correct and stuck-at-0 responses
    run_vec(8, 0, 1'b1, 32'h96, -1);
    run_vec(8, 1, 1'b1, 32'h96, -1);
    // single corrupted vector
    run_vec(4, 4, 1'b0, 32'h0, -1);
    // empty run
    run_vec(0, 0, 1'b0, 32'h0, -1);
    // start pulsed mid-run must be ignored
    run_vec(16, 0, 1'b0, 32'h0, 5);
    run_vec(1, 0, 1'b0, 32'h0, -1);
    run_vec(1, 3, 1'b0, 32'h0, -1);

    // reset in the middle of an 8-vector run
    num_vectors = 16'd8;
    for (int c = 0; c < 3; c++) begin
      start  = (c == 0);
      d_in   = 1'($urandom_range(0, 1));
      dout_v = 3'($urandom_range(0, 7));
      tick();
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
    check_all_zero("midrun_rst");
    rst = 1'b0;
    tick();
    check_all_zero("after_rst");
    run_vec(2, 0, 1'b0, 32'h0, -1);

    repeat (20) begin
      run_vec($urandom_range(0, 30), $urandom_range(0, 4), 1'b0, 32'h0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
